id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection, bubble insertion, branch flush and sticky halt.

---
 rtl/id_ex_hazard_reg.sv | 145 ++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, sticky halt and a saturating stall counter.
module id_ex_hazard_reg #(
   parameter int DATA_W  = 16,
   parameter int REG_W   = 4,
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [DATA_W-1:0]  id_rdata1,
   input  logic [DATA_W-1:0]  id_rdata2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               id_RegWrite,
   input  logic               id_MemRead,
   input  logic               id_MemWrite,
   input  logic               id_MemtoReg,
   input  logic               id_ALUSrc,
   input  logic [ALUOP_W-1:0] id_ALUOp,
   input  logic               id_halt,
   input  logic               branch_flush,
   output logic               id_ex_valid,
   output logic [REG_W-1:0]   id_ex_rs,
   output logic [REG_W-1:0]   id_ex_rt,
   output logic [REG_W-1:0]   id_ex_rd,
   output logic [DATA_W-1:0]  id_ex_rdata1,
   output logic [DATA_W-1:0]  id_ex_rdata2,
   output logic [DATA_W-1:0]  id_ex_imm,
   output logic               id_ex_RegWrite,
   output logic               id_ex_MemRead,
   output logic               id_ex_MemWrite,
   output logic               id_ex_MemtoReg,
   output logic               id_ex_ALUSrc,
   output logic [ALUOP_W-1:0] id_ex_ALUOp,
   output logic               id_ex_halt,
   output logic               stall,
   output logic               halted,
   output logic [CNT_W-1:0]   stall_count
);

   typedef struct packed {
      logic               valid;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rd;
      logic [DATA_W-1:0]  rdata1;
      logic [DATA_W-1:0]  rdata2;
      logic [DATA_W-1:0]  imm;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
      logic               alusrc;
      logic [ALUOP_W-1:0] aluop;
      logic               halt;
   } ex_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ex_t              ex_q, ex_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             hazard_s;

   // Load-use: a valid non-r0 load in EX feeds a register the ID instruction reads in EX.
   // Store data (rt of a store) is exempt because MEM-to-MEM forwarding supplies it.
   always_comb begin
      hazard_s = 1'b0;
      if (ex_q.valid && ex_q.memread && (|ex_q.rd) && id_valid) begin
         hazard_s = (id_uses_rs && (id_rs == ex_q.rd)) ||
                    (id_uses_rt && (id_rt == ex_q.rd) && !id_MemWrite);
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign stall = hazard_s && !branch_flush && !halted_q;

   always_comb begin
      ex_d          = ex_q;
      halted_d      = halted_q;
      stall_count_d = stall_count_q;
      if (halted_q) begin
         ex_d = ex_q;
      end else if (branch_flush) begin
         ex_d = '0;
      end else if (hazard_s) begin
         ex_d          = '0;
         stall_count_d = (stall_count_q == CNT_MAX) ? stall_count_q : stall_count_q + CNT_ONE;
      end else begin
         ex_d.valid    = id_valid;
         ex_d.rs       = id_rs;
         ex_d.rt       = id_rt;
         ex_d.rd       = id_rd;
         ex_d.rdata1   = id_rdata1;
         ex_d.rdata2   = id_rdata2;
         ex_d.imm      = id_imm;
         ex_d.regwrite = id_RegWrite && id_valid;
         ex_d.memread  = id_MemRead && id_valid;
         ex_d.memwrite = id_MemWrite && id_valid;
         ex_d.memtoreg = id_MemtoReg;
         ex_d.alusrc   = id_ALUSrc;
         ex_d.aluop    = id_ALUOp;
         ex_d.halt     = id_halt && id_valid;
         halted_d      = id_halt && id_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q          <= '0;
         halted_q      <= 1'b0;
         stall_count_q <= {CNT_W{1'b0}};
      end else begin
         ex_q          <= ex_d;
         halted_q      <= halted_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign id_ex_valid    = ex_q.valid;
   assign id_ex_rs       = ex_q.rs;
   assign id_ex_rt       = ex_q.rt;
   assign id_ex_rd       = ex_q.rd;
   assign id_ex_rdata1   = ex_q.rdata1;
   assign id_ex_rdata2   = ex_q.rdata2;
   assign id_ex_imm      = ex_q.imm;
   assign id_ex_RegWrite = ex_q.regwrite;
   assign id_ex_MemRead  = ex_q.memread;
   assign id_ex_MemWrite = ex_q.memwrite;
   assign id_ex_MemtoReg = ex_q.memtoreg;
   assign id_ex_ALUSrc   = ex_q.alusrc;
   assign id_ex_ALUOp    = ex_q.aluop;
   assign id_ex_halt     = ex_q.halt;
   assign halted         = halted_q;
   assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: directed scenarios then random
// instruction streams compared against a behavioural pipeline model.
module tb_id_ex_hazard_reg;

   localparam int CW      = 5;  // narrow counter so saturation is reachable quickly
   localparam int CNT_TOP = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rs, id_uses_rt;
   logic [3:0]  id_rs, id_rt, id_rd, id_ALUOp;
   logic [15:0] id_rdata1, id_rdata2, id_imm;
   logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_halt;
   logic        branch_flush;
   logic        id_ex_valid;
   logic [3:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ALUOp;
   logic [15:0] id_ex_rdata1, id_ex_rdata2, id_ex_imm;
   logic        id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemtoReg, id_ex_ALUSrc, id_ex_halt;
   logic        stall, halted;
   logic [CW-1:0] stall_count;

   id_ex_hazard_reg #(.DATA_W(16), .REG_W(4), .ALUOP_W(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
      .id_halt(id_halt), .branch_flush(branch_flush),
      .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
      .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2), .id_ex_imm(id_ex_imm),
      .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
      .id_ex_MemWrite(id_ex_MemWrite), .id_ex_MemtoReg(id_ex_MemtoReg),
      .id_ex_ALUSrc(id_ex_ALUSrc), .id_ex_ALUOp(id_ex_ALUOp), .id_ex_halt(id_ex_halt),
      .stall(stall), .halted(halted), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit valid; int rs, rt, rd; int rdata1, rdata2, imm;
      bit regwrite, memread, memwrite, memtoreg, alusrc; int aluop; bit halt;
   } stage_t;

   stage_t m_ex;
   bit     m_halted;
   int     m_cnt;
   int     tests = 0;
   int     fails = 0;
   int     halt_cycles = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind bits: {RegWrite, MemRead, MemWrite, halt}
   task automatic drive(input bit v, input int rs, input int rt, input int rd,
                        input bit urs, input bit urt, input logic [3:0] kind, input bit fl);
      id_valid = v; id_rs = 4'(rs); id_rt = 4'(rt); id_rd = 4'(rd);
      id_uses_rs = urs; id_uses_rt = urt;
      {id_RegWrite, id_MemRead, id_MemWrite, id_halt} = kind;
      id_MemtoReg = kind[2];
      id_ALUSrc = 1'($urandom);
      id_ALUOp = 4'($urandom);
      id_rdata1 = 16'($urandom); id_rdata2 = 16'($urandom); id_imm = 16'($urandom);
      branch_flush = fl;
   endtask

   function automatic stage_t bubble();
      stage_t b;
      b = '{default: 0};
      return b;
   endfunction

   task automatic step(input bit rst);
      bit load_in_ex, reads_it, hz, exp_stall;
      rst_n = !rst;
      #1;
      load_in_ex = m_ex.valid && m_ex.memread && (m_ex.rd != 0);
      reads_it   = (id_uses_rs && (int'(id_rs) == m_ex.rd)) ||
                   (id_uses_rt && (int'(id_rt) == m_ex.rd) && !id_MemWrite);
      hz         = load_in_ex && id_valid && reads_it;
      exp_stall  = hz && !branch_flush && !m_halted;
      check("stall", stall, exp_stall);
      if (rst) begin
         m_ex = bubble(); m_halted = 0; m_cnt = 0;
      end else if (m_halted) begin
         m_cnt = m_cnt;
      end else if (branch_flush || hz) begin
         m_ex = bubble();
         if (!branch_flush) m_cnt = (m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP;
      end else begin
         m_ex.valid = id_valid; m_ex.rs = id_rs; m_ex.rt = id_rt; m_ex.rd = id_rd;
         m_ex.rdata1 = id_rdata1; m_ex.rdata2 = id_rdata2; m_ex.imm = id_imm;
         m_ex.regwrite = id_RegWrite && id_valid;
         m_ex.memread  = id_MemRead && id_valid;
         m_ex.memwrite = id_MemWrite && id_valid;
         m_ex.memtoreg = id_MemtoReg; m_ex.alusrc = id_ALUSrc; m_ex.aluop = id_ALUOp;
         m_ex.halt = id_halt && id_valid;
         m_halted  = id_halt && id_valid;
      end
      @(posedge clk);
      #1;
      check("valid", id_ex_valid, m_ex.valid);
      check("rs", id_ex_rs, m_ex.rs);
      check("rt", id_ex_rt, m_ex.rt);
      check("rd", id_ex_rd, m_ex.rd);
      check("rdata1", id_ex_rdata1, m_ex.rdata1);
      check("rdata2", id_ex_rdata2, m_ex.rdata2);
      check("imm", id_ex_imm, m_ex.imm);
      check("RegWrite", id_ex_RegWrite, m_ex.regwrite);
      check("MemRead", id_ex_MemRead, m_ex.memread);
      check("MemWrite", id_ex_MemWrite, m_ex.memwrite);
      check("MemtoReg", id_ex_MemtoReg, m_ex.memtoreg);
      check("ALUSrc", id_ex_ALUSrc, m_ex.alusrc);
      check("ALUOp", id_ex_ALUOp, m_ex.aluop);
      check("halt", id_ex_halt, m_ex.halt);
      check("halted", halted, m_halted);
      check("stall_count", stall_count, m_cnt);
   endtask

   initial begin
      m_ex = bubble(); m_halted = 0; m_cnt = 0;
      // Reset with random inputs
      rst_n = 1'b0;
      drive(1, 3, 3, 3, 1, 1, 4'b1100, 0);
      @(posedge clk); #1;
      drive(1, 2, 5, 7, 1, 1, 4'($urandom), 1'($urandom));
      step(1);
      drive(1, 1, 1, 1, 1, 1, 4'b1100, 0);
      step(1);
      check("reset_valid", id_ex_valid, 1'b0);

      // LW r3 then dependent ADD r4,r3,r5: one stall, then capture
      drive(1, 1, 3, 3, 1, 0, 4'b1100, 0); step(0);
      drive(1, 3, 5, 4, 1, 1, 4'b1000, 0); step(0);
      check("lu_bubble", id_ex_valid, 1'b0);
      step(0);
      check("lu_capture_rd", id_ex_rd, 4'd4);
      check("lu_count", stall_count, 5'd1);

      // LW r3 then SW r3,(r6): no stall on store data
      drive(1, 1, 3, 3, 1, 0, 4'b1100, 0); step(0);
      drive(1, 6, 3, 0, 1, 1, 4'b0010, 0); step(0);
      check("sw_capture", id_ex_MemWrite, 1'b1);

      // LW r0 then ADD r1,r0,r0: r0 exempt
      drive(1, 1, 0, 0, 1, 0, 4'b1100, 0); step(0);
      drive(1, 0, 0, 1, 1, 1, 4'b1000, 0); step(0);
      check("r0_capture", id_ex_valid, 1'b1);

      // LW r2 then dependent ADD with simultaneous flush
      drive(1, 1, 2, 2, 1, 0, 4'b1100, 0); step(0);
      drive(1, 2, 2, 5, 1, 1, 4'b1000, 1); step(0);
      check("flush_bubble", id_ex_valid, 1'b0);
      check("flush_count", stall_count, 5'd1);

      // Reset in the middle of a stall
      drive(1, 1, 3, 3, 1, 0, 4'b1100, 0); step(0);
      drive(1, 3, 0, 4, 1, 0, 4'b1000, 0); step(1);
      step(0);

      // Repeated load-use on the same register drives the counter to saturation
      drive(1, 1, 1, 1, 1, 0, 4'b1100, 0);
      for (int i = 0; i < 2 * CNT_TOP + 8; i++) step(0);
      check("sat_count", stall_count, 5'h1F);

      // HLT reaches EX: everything freezes until reset
      drive(1, 0, 0, 0, 0, 0, 4'b0001, 0); step(0);
      check("halt_set", halted, 1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
         step(0);
      end
      check("halt_sticky", halted, 1'b1);
      step(1);

      // Random instruction streams with frequent register collisions
      for (int i = 0; i < 600; i++) begin
         logic [3:0] kind;
         case ($urandom_range(0, 3))
            0: kind = 4'b1000;
            1: kind = 4'b1100;
            2: kind = 4'b0010;
            default: kind = 4'($urandom) & 4'b1110;
         endcase
         if ($urandom_range(0, 59) == 0) kind[0] = 1'b1;
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom), kind,
               $urandom_range(0, 7) == 0);
         halt_cycles = m_halted ? halt_cycles + 1 : 0;
         step((halt_cycles > 3) || ($urandom_range(0, 99) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
